// File: rtl/fp_mult_sched.sv
// rtl/fp_mult_sched.sv - round-robin sharing of one pipelined fp multiplier between NREQ requesters
module fp_mult_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          mult_a,
  output logic [31:0]          mult_b,
  input  logic [31:0]          mult_z,
  input  logic [7:0]           mult_status,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_z,
  output logic [7:0]           rsp_status,
  output logic                 busy,
  output logic [15:0]          issue_count
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = LAT + 1;

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_found;
  logic              hs;
  int                gnt_int;
  int                gnt_off;
  logic [2*NREQ-1:0] valid_rot;
  logic [31:0]       sel_a, sel_b;
  logic [31:0]       mult_a_q, mult_b_q;
  logic [15:0]       issue_cnt_q;
  logic [DEPTH-1:0]  tag_v_q;
  logic [IW-1:0]     tag_o_q [DEPTH];

  // Rotate the request vector so that offset 0 is the pointer position.
  always_comb begin
    valid_rot = {req_valid, req_valid} >> ptr_q;
    gnt_found = 1'b0;
    gnt_off   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && valid_rot[k]) begin
        gnt_found = 1'b1;
        gnt_off   = k;
      end
    end
    gnt_int = int'(ptr_q) + gnt_off;
    if (gnt_int >= NREQ) gnt_int = gnt_int - NREQ;
    gnt_idx = IW'(gnt_int);
    hs      = gnt_found && !rst;
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = hs && (gnt_int == i);
      if (gnt_int == i) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_int == NREQ - 1) ? '0 : IW'(gnt_int + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      issue_cnt_q <= '0;
      tag_v_q     <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tag_v_q <= {tag_v_q[DEPTH-2:0], hs};
      if (hs) begin
        mult_a_q    <= sel_a;
        mult_b_q    <= sel_b;
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
    end
  end

  // Owner indices need no reset: they are only decoded under their valid bit.
  always_ff @(posedge clk) begin
    tag_o_q[0] <= gnt_idx;
    for (int s = 1; s < DEPTH; s++) tag_o_q[s] <= tag_o_q[s-1];
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_valid[i] = tag_v_q[DEPTH-1] && (int'(tag_o_q[DEPTH-1]) == i);
  end

  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign rsp_z       = mult_z;
  assign rsp_status  = mult_status;
  assign busy        = |tag_v_q;
  assign issue_count = issue_cnt_q;

endmodule

// File: tb/tb_fp_mult_sched.sv
// tb/tb_fp_mult_sched.sv - directed bench for fp_mult_sched with a behavioural LAT-stage multiplier
module tb_fp_mult_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [31:0]       mult_a, mult_b, mult_z;
  logic [7:0]        mult_status;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_z;
  logic [7:0]        rsp_status;
  logic              busy;
  logic [15:0]       issue_count;

  int checks = 0;
  int errors = 0;

  fp_mult_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b),
    .mult_z(mult_z), .mult_status(mult_status),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_status(rsp_status),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply; exact for the short-mantissa operands used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  logic [31:0] zp [LAT];
  logic [7:0]  sp [LAT];
  always @(posedge clk) begin
    zp[0] <= fmul(mult_a, mult_b);
    sp[0] <= mult_a[31:24];
    for (int s = 1; s < LAT; s++) begin
      zp[s] <= zp[s-1];
      sp[s] <= sp[s-1];
    end
  end
  assign mult_z      = zp[LAT-1];
  assign mult_status = sp[LAT-1];

  logic [31:0] ta [8] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hC0000000,
                          32'h40800000, 32'h40400000, 32'h3F000000, 32'h3F800000};
  logic [31:0] tb [8] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3F000000,
                          32'h40800000, 32'h40400000, 32'h3F000000, 32'hBF800000};
  logic [31:0] tp [8] = '{32'h40000000, 32'h40C00000, 32'h40100000, 32'hBF800000,
                          32'h41800000, 32'h41100000, 32'h3E800000, 32'hBF800000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
    end
  endtask

  initial begin
    int bad;
    int got;
    logic [31:0] bexp;

    rst = 1'b1;
    req_valid = 4'hF;
    set_all(32'h3F800000, 32'h3F800000);
    tick();
    tick();
    chk("rst_ready", {28'd0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_issue_count", {16'd0, issue_count}, 32'h0);
    chk("rst_mult_a", mult_a, 32'h0);
    chk("rst_mult_b", mult_b, 32'h0);

    rst = 1'b0;
    #1;
    chk("first_ready", {28'd0, req_ready}, 32'h1);
    req_valid = 4'h0;
    #1;

    // Single operation from requester 1.
    req_valid = 4'b0010;
    req_a[63:32] = 32'h3F800000;
    req_b[63:32] = 32'h40000000;
    #1;
    chk("single_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'h0;
    #1;
    chk("single_mult_a", mult_a, 32'h3F800000);
    chk("single_mult_b", mult_b, 32'h40000000);
    chk("single_busy_n1", {31'd0, busy}, 32'h1);
    chk("single_rsp_n1", {28'd0, rsp_valid}, 32'h0);
    chk("single_count", {16'd0, issue_count}, 32'h1);
    tick();
    chk("single_busy_n2", {31'd0, busy}, 32'h1);
    chk("single_rsp_n2", {28'd0, rsp_valid}, 32'h0);
    tick();
    chk("single_rsp_n3", {28'd0, rsp_valid}, 32'h2);
    chk("single_z_n3", rsp_z, 32'h40000000);
    chk("single_status_n3", {24'd0, rsp_status}, 32'h3F);
    chk("single_busy_n3", {31'd0, busy}, 32'h1);
    tick();
    chk("single_rsp_n4", {28'd0, rsp_valid}, 32'h0);
    chk("single_busy_n4", {31'd0, busy}, 32'h0);

    // Requester 3 alone, from pointer 2; leaves pointer at 0.
    req_valid = 4'b1000;
    req_a[127:96] = 32'h40200000;
    req_b[127:96] = 32'h40000000;
    #1;
    chk("r3_ready", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    chk("r3_rsp", {28'd0, rsp_valid}, 32'h8);
    chk("r3_z", rsp_z, 32'h40A00000);
    tick();

    // Saturation: all four valid for 8 cycles, operands change per cycle.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        req_valid = 4'hF;
        set_all(ta[k], tb[k]);
      end else begin
        req_valid = 4'h0;
      end
      #1;
      if (k < 8) chk($sformatf("sat_grant%0d", k), {28'd0, req_ready}, 32'h1 << (k % 4));
      if (k >= 3) begin
        chk($sformatf("sat_rsp%0d", k - 3), {28'd0, rsp_valid}, 32'h1 << ((k - 3) % 4));
        chk($sformatf("sat_z%0d", k - 3), rsp_z, tp[k - 3]);
        chk($sformatf("sat_status%0d", k - 3), {24'd0, rsp_status}, {24'd0, ta[k - 3][31:24]});
      end
      tick();
    end
    chk("sat_count", {16'd0, issue_count}, 32'd10);

    // Fairness: move pointer to 1, then only requesters 0 and 2 valid.
    req_valid = 4'b0001;
    #1;
    chk("fair_pre", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fair_grant%0d", k), {28'd0, req_ready}, (k % 2 == 0) ? 32'h4 : 32'h1);
      tick();
    end
    req_valid = 4'h0;
    for (int k = 0; k < 4; k++) tick();

    // Reset with an operation in flight (pointer is 1, so requester 3 wins).
    req_valid = 4'b1000;
    #1;
    chk("rif_ready", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'h0;
    rst = 1'b1;
    #1;
    chk("rif_rsp_n1", {28'd0, rsp_valid}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rif_busy", {31'd0, busy}, 32'h0);
    chk("rif_count", {16'd0, issue_count}, 32'h0);
    bad = 0;
    for (int k = 2; k <= 6; k++) begin
      if (rsp_valid !== 4'h0) bad++;
      tick();
    end
    chk("rif_no_rsp", bad, 0);
    req_valid = 4'b1100;
    #1;
    chk("rif_ptr0_grant", {28'd0, req_ready}, 32'h4);
    req_valid = 4'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;

    // Counter wrap: 65536 back-to-back operations from requester 0.
    bad = 0;
    got = 0;
    req_a[31:0] = 32'h3F800000;
    for (int k = 0; k < 65539; k++) begin
      if (k < 65536) begin
        req_valid = 4'b0001;
        req_b[31:0] = 32'h40000000 | (32'(k) << 7);
      end else begin
        req_valid = 4'h0;
      end
      #1;
      if (k == 65535) chk("wrap_count_ffff", {16'd0, issue_count}, 32'h0000FFFF);
      if (k >= 3) begin
        bexp = 32'h40000000 | (32'(k - 3) << 7);
        if (rsp_valid === 4'b0001) got++;
        if (rsp_valid !== 4'b0001 || rsp_z !== bexp) bad++;
      end
      tick();
    end
    chk("wrap_count_zero", {16'd0, issue_count}, 32'h0);
    chk("wrap_responses", got, 65536);
    chk("wrap_order", bad, 0);
    chk("wrap_idle", {31'd0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
